// File: rtl/decode_if.sv
// Bundles the decode stage's fetch, register-file, bypass and execute-side signals.
// The slave modport is the decode stage; master is whatever drives it.
interface decode_if;
  logic [31:0] pc_in;
  logic [31:0] ir_in;
  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic [4:0]  ex_rc;
  logic [4:0]  mem_rc;
  logic [4:0]  wb_rc;
  logic        ex_wen;
  logic        mem_wen;
  logic        wb_wen;
  logic [31:0] ex_data;
  logic [31:0] mem_data;
  logic [31:0] wb_data;
  logic        ex_is_ld;
  logic        stall;
  logic        zr;
  logic        op_jmp;
  logic        op_beq;
  logic        op_bne;
  logic        op_ill;
  logic [31:0] br_addr;
  logic [31:0] j_addr;
  logic [31:0] pc_ex;
  logic [31:0] ir_ex;
  logic [31:0] a_ex;
  logic [31:0] b_ex;
  logic [31:0] d_ex;

  modport slave (
    input  pc_in, ir_in, ra_data, rb_data,
           ex_rc, mem_rc, wb_rc, ex_wen, mem_wen, wb_wen,
           ex_data, mem_data, wb_data, ex_is_ld,
    output ra_addr, rb_addr, stall, zr, op_jmp, op_beq, op_bne, op_ill,
           br_addr, j_addr, pc_ex, ir_ex, a_ex, b_ex, d_ex
  );

  modport master (
    output pc_in, ir_in, ra_data, rb_data,
           ex_rc, mem_rc, wb_rc, ex_wen, mem_wen, wb_wen,
           ex_data, mem_data, wb_data, ex_is_ld,
    input  ra_addr, rb_addr, stall, zr, op_jmp, op_beq, op_bne, op_ill,
           br_addr, j_addr, pc_ex, ir_ex, a_ex, b_ex, d_ex
  );
endinterface

// File: rtl/decode.sv
// Beta-style decode stage: holds the fetched instruction, bypasses operands from
// EX/MEM/WB, detects load-use hazards, resolves branch targets and feeds EX.
module decode #(
  parameter logic [31:0] NOP_INST = 32'h83FF_F800,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  decode_if.slave  bus
);

  logic [31:0] pc_rf;
  logic [31:0] ir_rf;
  logic [5:0]  opcode;
  logic [31:0] lit_sext;
  logic        is_st;
  logic        legal;
  logic        use_lit;
  logic        rb_used;
  logic        hazard;
  logic        decode_en;
  logic [31:0] a_val;
  logic [31:0] b_val;

  function automatic logic [31:0] bypass(
    input logic [4:0]  addr,
    input logic [31:0] rf_data,
    input logic [4:0]  ex_rc,
    input logic        ex_wen,
    input logic [31:0] ex_data,
    input logic [4:0]  mem_rc,
    input logic        mem_wen,
    input logic [31:0] mem_data,
    input logic [4:0]  wb_rc,
    input logic        wb_wen,
    input logic [31:0] wb_data
  );
    if (addr == 5'd31)                    return 32'd0;
    else if (ex_wen && ex_rc == addr)     return ex_data;
    else if (mem_wen && mem_rc == addr)   return mem_data;
    else if (wb_wen && wb_rc == addr)     return wb_data;
    else                                  return rf_data;
  endfunction

  assign opcode   = ir_rf[31:26];
  assign lit_sext = {{16{ir_rf[15]}}, ir_rf[15:0]};
  assign is_st    = (opcode == 6'h19);

  assign bus.ra_addr = ir_rf[20:16];
  assign bus.rb_addr = is_st ? ir_rf[25:21] : ir_rf[15:11];

  // Opcode classification: legality, literal B operand, and whether the rb port is read.
  always_comb begin
    legal   = 1'b0;
    use_lit = 1'b0;
    rb_used = 1'b0;
    case (opcode) inside
      6'h18, 6'h1F:                 begin legal = 1'b1; use_lit = 1'b1; end
      6'h19:                        begin legal = 1'b1; use_lit = 1'b1; rb_used = 1'b1; end
      6'h1B, 6'h1D, 6'h1E:          legal = 1'b1;
      [6'h20:6'h26], [6'h28:6'h2D]: begin legal = 1'b1; rb_used = 1'b1; end
      [6'h30:6'h36], [6'h38:6'h3D]: begin legal = 1'b1; use_lit = 1'b1; end
      6'h37, [6'h3E:6'h3F]:         use_lit = 1'b1;
      default:                      ;
    endcase
  end

  assign a_val = bypass(bus.ra_addr, bus.ra_data, bus.ex_rc, bus.ex_wen, bus.ex_data,
                        bus.mem_rc, bus.mem_wen, bus.mem_data, bus.wb_rc, bus.wb_wen, bus.wb_data);
  assign b_val = bypass(bus.rb_addr, bus.rb_data, bus.ex_rc, bus.ex_wen, bus.ex_data,
                        bus.mem_rc, bus.mem_wen, bus.mem_data, bus.wb_rc, bus.wb_wen, bus.wb_data);

  // A load in EX cannot forward its result yet, so a dependent instruction waits one cycle.
  assign hazard = bus.ex_is_ld && bus.ex_wen && (bus.ex_rc != 5'd31) &&
                  ((bus.ex_rc == bus.ra_addr) || (rb_used && (bus.ex_rc == bus.rb_addr)));
  assign bus.stall = rst_n && hazard;
  assign decode_en = rst_n && !hazard;

  assign bus.op_jmp  = decode_en && (opcode == 6'h1B);
  assign bus.op_beq  = decode_en && (opcode == 6'h1D);
  assign bus.op_bne  = decode_en && (opcode == 6'h1E);
  assign bus.op_ill  = decode_en && !legal;
  assign bus.zr      = (a_val == 32'd0);
  assign bus.br_addr = pc_rf + {lit_sext[29:0], 2'b00};
  assign bus.j_addr  = {a_val[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_rf <= RESET_PC;
      ir_rf <= NOP_INST;
    end else if (!bus.stall) begin
      pc_rf <= bus.pc_in;
      ir_rf <= bus.ir_in;
    end
  end

  // A stall injects a bubble into EX; illegal opcodes are turned into NOPs as they pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.pc_ex <= RESET_PC;
      bus.ir_ex <= NOP_INST;
      bus.a_ex  <= 32'd0;
      bus.b_ex  <= 32'd0;
      bus.d_ex  <= 32'd0;
    end else if (bus.stall) begin
      bus.pc_ex <= 32'd0;
      bus.ir_ex <= NOP_INST;
      bus.a_ex  <= 32'd0;
      bus.b_ex  <= 32'd0;
      bus.d_ex  <= 32'd0;
    end else begin
      bus.pc_ex <= pc_rf;
      bus.ir_ex <= legal ? ir_rf : NOP_INST;
      bus.a_ex  <= a_val;
      bus.b_ex  <= use_lit ? lit_sext : b_val;
      bus.d_ex  <= b_val;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: a table of directed vectors plus hand-written
// sequences for reset, latency, load-use stall recovery and reset during a stall.
module tb_decode;

  localparam logic [31:0] NOP = 32'h83FF_F800;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  decode_if bus ();

  decode #(.NOP_INST(NOP), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ir, ra_data, rb_data;
    logic [4:0]  ex_rc, mem_rc, wb_rc;
    logic        ex_wen, mem_wen, wb_wen, ex_is_ld;
    logic [31:0] ex_data, mem_data, wb_data;
    logic [4:0]  e_ra_addr, e_rb_addr;
    logic        e_stall, e_zr, e_jmp, e_beq, e_bne, e_ill;
    logic [31:0] e_br, e_j, e_ir_ex, e_pc_ex, e_a, e_b, e_d;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] ins_r(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'd0};
  endfunction

  function automatic logic [31:0] ins_l(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ra_data  = 32'd0;
    bus.rb_data  = 32'd0;
    bus.ex_rc    = 5'd0;
    bus.mem_rc   = 5'd0;
    bus.wb_rc    = 5'd0;
    bus.ex_wen   = 1'b0;
    bus.mem_wen  = 1'b0;
    bus.wb_wen   = 1'b0;
    bus.ex_is_ld = 1'b0;
    bus.ex_data  = 32'd0;
    bus.mem_data = 32'd0;
    bus.wb_data  = 32'd0;
  endtask

  // Loads the instruction into the held register, then applies the bypass context.
  task automatic apply_stimulus(input vec_t v);
    idle_inputs();
    bus.pc_in = v.pc;
    bus.ir_in = v.ir;
    tick();
    bus.pc_in    = 32'd0;
    bus.ir_in    = NOP;
    bus.ra_data  = v.ra_data;
    bus.rb_data  = v.rb_data;
    bus.ex_rc    = v.ex_rc;
    bus.mem_rc   = v.mem_rc;
    bus.wb_rc    = v.wb_rc;
    bus.ex_wen   = v.ex_wen;
    bus.mem_wen  = v.mem_wen;
    bus.wb_wen   = v.wb_wen;
    bus.ex_is_ld = v.ex_is_ld;
    bus.ex_data  = v.ex_data;
    bus.mem_data = v.mem_data;
    bus.wb_data  = v.wb_data;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // pc, ir, ra_data, rb_data, ex/mem/wb rc, ex/mem/wb wen, ex_is_ld, ex/mem/wb data,
    // ra_addr, rb_addr, stall, zr, jmp, beq, bne, ill, br_addr, j_addr, ir_ex, pc_ex, a, b, d
    vecs[0]  = '{32'h40, ins_r(6'h20, 5'd3, 5'd1, 5'd2), 32'hAAAA, 32'hBBBB, 5'd1, 5'd1, 5'd2,
                 1'b1, 1'b1, 1'b1, 1'b0, 32'd11, 32'd22, 32'd33, 5'd1, 5'd2,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4040, 32'h8,
                 ins_r(6'h20, 5'd3, 5'd1, 5'd2), 32'h40, 32'd11, 32'd33, 32'd33};
    vecs[1]  = '{32'h80, ins_r(6'h20, 5'd5, 5'd4, 5'd6), 32'd7, 32'd8, 5'd4, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h99, 32'd0, 32'd0, 5'd4, 5'd6,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC080, 32'h98,
                 NOP, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[2]  = '{32'h100, ins_l(6'h1D, 5'd2, 5'd31, 16'hFFFF), 32'd5, 32'd6, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd31,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFC, 32'h0,
                 ins_l(6'h1D, 5'd2, 5'd31, 16'hFFFF), 32'h100, 32'd0, 32'd0, 32'd0};
    vecs[3]  = '{32'h200, ins_l(6'h1B, 5'd1, 5'd7, 16'h0000), 32'h1234, 32'h77, 5'd0, 5'd7, 5'd7,
                 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h2003, 32'h5555, 5'd7, 5'd0,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h2000,
                 ins_l(6'h1B, 5'd1, 5'd7, 16'h0000), 32'h200, 32'h2003, 32'h77, 32'h77};
    vecs[4]  = '{32'h300, ins_r(6'h00, 5'd1, 5'd2, 5'd3), 32'h10, 32'h20, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd2, 5'd3,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h6300, 32'h10,
                 NOP, 32'h300, 32'h10, 32'h20, 32'h20};
    vecs[5]  = '{32'h300, ins_r(6'h00, 5'd1, 5'd2, 5'd3), 32'h10, 32'h20, 5'd2, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h44, 32'd0, 32'd0, 5'd2, 5'd3,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h6300, 32'h44,
                 NOP, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[6]  = '{32'h400, ins_l(6'h19, 5'd9, 5'd8, 16'hFFF0), 32'h1000, 32'h1, 5'd0, 5'd0, 5'd9,
                 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hDEAD, 5'd8, 5'd9,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3C0, 32'h1000,
                 ins_l(6'h19, 5'd9, 5'd8, 16'hFFF0), 32'h400, 32'h1000, 32'hFFFF_FFF0, 32'hDEAD};
    vecs[7]  = '{32'h400, ins_l(6'h19, 5'd9, 5'd8, 16'hFFF0), 32'h1000, 32'h1, 5'd9, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'h5, 32'd0, 32'd0, 5'd8, 5'd9,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3C0, 32'h1000,
                 NOP, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[8]  = '{32'h500, ins_l(6'h30, 5'd1, 5'd2, 16'h0805), 32'h10, 32'h3, 5'd1, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF, 32'd0, 32'd0, 5'd2, 5'd1,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2514, 32'h10,
                 ins_l(6'h30, 5'd1, 5'd2, 16'h0805), 32'h500, 32'h10, 32'h805, 32'hFF};
    vecs[9]  = '{32'h600, ins_r(6'h2E, 5'd31, 5'd31, 5'd31), 32'h1, 32'h2, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd31,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_E600, 32'h0,
                 NOP, 32'h600, 32'd0, 32'd0, 32'd0};
    vecs[10] = '{32'h700, ins_l(6'h1E, 5'd0, 5'd3, 16'h0010), 32'h0, 32'h9, 5'd0, 5'd0, 5'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h740, 32'h0,
                 ins_l(6'h1E, 5'd0, 5'd3, 16'h0010), 32'h700, 32'd0, 32'h9, 32'h9};
    vecs[11] = '{32'h800, ins_r(6'h20, 5'd5, 5'd31, 5'd6), 32'h11, 32'h66, 5'd31, 5'd0, 5'd0,
                 1'b1, 1'b0, 1'b0, 1'b1, 32'hAB, 32'd0, 32'd0, 5'd31, 5'd6,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC800, 32'h0,
                 ins_r(6'h20, 5'd5, 5'd31, 5'd6), 32'h800, 32'd0, 32'h66, 32'h66};

    idle_inputs();
    bus.pc_in = 32'h1234;
    bus.ir_in = 32'h0;
    rst_n     = 1'b0;
    tick();
    check_output("reset_ir_ex", bus.ir_ex, NOP);
    check_output("reset_pc_ex", bus.pc_ex, 32'h0);
    check_output("reset_a_ex", bus.a_ex, 32'h0);
    check_output("reset_stall", {31'd0, bus.stall}, 32'd0);
    check_output("reset_ops", {28'd0, bus.op_jmp, bus.op_beq, bus.op_bne, bus.op_ill}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("post_reset_ops", {27'd0, bus.stall, bus.op_jmp, bus.op_beq, bus.op_bne, bus.op_ill}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("v%0d_ra_addr", i), {27'd0, bus.ra_addr}, {27'd0, vecs[i].e_ra_addr});
      check_output($sformatf("v%0d_rb_addr", i), {27'd0, bus.rb_addr}, {27'd0, vecs[i].e_rb_addr});
      check_output($sformatf("v%0d_stall", i), {31'd0, bus.stall}, {31'd0, vecs[i].e_stall});
      check_output($sformatf("v%0d_zr", i), {31'd0, bus.zr}, {31'd0, vecs[i].e_zr});
      check_output($sformatf("v%0d_ops", i), {28'd0, bus.op_jmp, bus.op_beq, bus.op_bne, bus.op_ill},
                   {28'd0, vecs[i].e_jmp, vecs[i].e_beq, vecs[i].e_bne, vecs[i].e_ill});
      check_output($sformatf("v%0d_br_addr", i), bus.br_addr, vecs[i].e_br);
      check_output($sformatf("v%0d_j_addr", i), bus.j_addr, vecs[i].e_j);
      tick();
      check_output($sformatf("v%0d_ir_ex", i), bus.ir_ex, vecs[i].e_ir_ex);
      check_output($sformatf("v%0d_pc_ex", i), bus.pc_ex, vecs[i].e_pc_ex);
      check_output($sformatf("v%0d_a_ex", i), bus.a_ex, vecs[i].e_a);
      check_output($sformatf("v%0d_b_ex", i), bus.b_ex, vecs[i].e_b);
      check_output($sformatf("v%0d_d_ex", i), bus.d_ex, vecs[i].e_d);
    end

    // Two-edge latency from ir_in to ir_ex with no hazards.
    idle_inputs();
    bus.pc_in = 32'h904;
    bus.ir_in = ins_r(6'h21, 5'd1, 5'd2, 5'd3);
    tick();
    bus.ir_in = NOP;
    bus.pc_in = 32'h908;
    tick();
    check_output("latency_ir_ex", bus.ir_ex, ins_r(6'h21, 5'd1, 5'd2, 5'd3));
    check_output("latency_pc_ex", bus.pc_ex, 32'h904);

    // Load-use stall for exactly one cycle, then the held ADD issues.
    bus.pc_in = 32'h80;
    bus.ir_in = ins_r(6'h20, 5'd5, 5'd4, 5'd6);
    tick();
    bus.pc_in    = 32'h84;
    bus.ir_in    = ins_r(6'h22, 5'd7, 5'd7, 5'd7);
    bus.ex_is_ld = 1'b1;
    bus.ex_wen   = 1'b1;
    bus.ex_rc    = 5'd4;
    bus.ex_data  = 32'h5;
    #1;
    check_output("ldu_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    check_output("ldu_bubble", bus.ir_ex, NOP);
    check_output("ldu_pc_held", bus.br_addr, 32'hC080);
    idle_inputs();
    bus.ra_data = 32'h21;
    #1;
    check_output("ldu_stall_clear", {31'd0, bus.stall}, 32'd0);
    tick();
    check_output("ldu_issue_ir", bus.ir_ex, ins_r(6'h20, 5'd5, 5'd4, 5'd6));
    check_output("ldu_issue_pc", bus.pc_ex, 32'h80);
    check_output("ldu_issue_a", bus.a_ex, 32'h21);
    check_output("ldu_next_held", bus.br_addr, 32'h84 + 32'h0000_E000);

    // Reset arriving during a stall discards the stalled instruction.
    bus.pc_in = 32'hA0;
    bus.ir_in = ins_r(6'h20, 5'd5, 5'd4, 5'd6);
    tick();
    bus.ex_is_ld = 1'b1;
    bus.ex_wen   = 1'b1;
    bus.ex_rc    = 5'd4;
    #1;
    check_output("rst_stall_pre", {31'd0, bus.stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("rst_stall_low", {31'd0, bus.stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    idle_inputs();
    bus.pc_in = 32'hC0;
    bus.ir_in = NOP;
    #1;
    check_output("rst_stall_ir_ex", bus.ir_ex, NOP);
    check_output("rst_stall_pc_rf", bus.br_addr, 32'hFFFF_E000);
    tick();
    check_output("rst_stall_discard_ir", bus.ir_ex, NOP);
    check_output("rst_stall_discard_pc", bus.pc_ex, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
